pc_gen_bp: RTL and testbench

- Successor to the combinational next-PC selector.
- Owns the architectural fetch PC register.
- Adds a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and a delay-slot-aware redirect state machine.
- Sits between the F stage (drives `pc`) and the D stage (returns branch resolution); interrupt and eret redirects keep absolute priority.

---
 rtl/pc_gen_bp.sv | 167 ++++++++++++++++
 tb/tb_pc_gen_bp.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_bp.sv
// Fetch PC generator with a direct-mapped BTB (2-bit counters) and delay-slot redirect FSM.
// Optional performance counters are built when PC_GEN_PERF_EN is defined.
module pc_gen_bp #(
    parameter int          ENTRIES    = 16,
    parameter logic [31:0] RESET_ADDR = 32'hBFC00000,
    parameter logic [31:0] INT_ADDR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        int_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        flush,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    generate
        if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
            $error("pc_gen_bp: ENTRIES must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pend, pend_nxt;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];
    logic [1:0]         ctr_mem [ENTRIES];

    logic [IDX_W-1:0] idx, ridx;
    logic [TAG_W-1:0] tag, rtag;
    logic             hit, rhit;
    logic             mispredict;
    logic [31:0]      cp;
    logic             unused_bits;

    function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign unused_bits = &{1'b0, res_pc[1:0]};

    assign idx  = pc[IDX_W+1:2];
    assign tag  = pc[31:IDX_W+2];
    assign hit  = valid[idx] && (tag_mem[idx] == tag);

    assign ridx = res_pc[IDX_W+1:2];
    assign rtag = res_pc[31:IDX_W+2];
    assign rhit = valid[ridx] && (tag_mem[ridx] == rtag);

    assign mispredict = res_valid &&
                        ((res_taken != res_pred_taken) ||
                         (res_taken && (res_target != res_pred_target)));
    // Not-taken resumes after the delay slot, which has already been fetched.
    assign cp = res_taken ? res_target : res_pc + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_ADDR;
            state <= SEQ;
            pend  <= 32'h0;
        end else begin
            pc    <= pc_nxt;
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Redirects come first so they override stall and abandon a pending slot target.
    always_comb begin
        pc_nxt    = pc;
        state_nxt = state;
        pend_nxt  = pend;
        if (int_req) begin
            pc_nxt    = INT_ADDR;
            state_nxt = SEQ;
        end else if (eret) begin
            pc_nxt    = epc;
            state_nxt = SEQ;
        end else if (mispredict) begin
            pc_nxt    = cp;
            state_nxt = SEQ;
        end else if (!stall) begin
            if (state == SEQ && pred_taken) begin
                pc_nxt    = pc + 32'd4;
                pend_nxt  = pred_target;
                state_nxt = SLOT;
            end else if (state == SLOT) begin
                pc_nxt    = pend;
                state_nxt = SEQ;
            end else begin
                pc_nxt = pc + 32'd4;
            end
        end
    end

    always_comb begin
        pred_taken  = hit && ctr_mem[idx][1] && (state == SEQ);
        pred_target = pred_taken ? tgt_mem[idx] : 32'h0;
        flush       = int_req || eret || mispredict;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (res_valid && !rhit && res_taken) begin
            valid[ridx] <= 1'b1;
        end
    end

    // Payload arrays need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (res_valid) begin
            if (rhit) begin
                ctr_mem[ridx] <= ctr_sat(ctr_mem[ridx], res_taken);
                if (res_taken)
                    tgt_mem[ridx] <= res_target;
            end else if (res_taken) begin
                tag_mem[ridx] <= rtag;
                tgt_mem[ridx] <= res_target;
                ctr_mem[ridx] <= 2'b10;
            end
        end
    end

`ifdef PC_GEN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches    <= 32'h0;
            perf_mispredicts <= 32'h0;
        end else begin
            if (res_valid)
                perf_branches <= perf_branches + 32'd1;
            if (mispredict)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`else
    assign perf_branches    = 32'h0;
    assign perf_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_pc_gen_bp.sv
// Scoreboard bench for pc_gen_bp: a reference model pushes expected outputs each cycle,
// a negedge monitor pops and compares them; directed plan followed by random traffic.
module tb_pc_gen_bp;

    localparam int          ENTRIES    = 16;
    localparam logic [31:0] RESET_ADDR = 32'hBFC00000;
    localparam logic [31:0] INT_ADDR   = 32'hBFC00380;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        int_req;
    logic        eret;
    logic [31:0] epc;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    pc_gen_bp #(
        .ENTRIES   (ENTRIES),
        .RESET_ADDR(RESET_ADDR),
        .INT_ADDR  (INT_ADDR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .int_req         (int_req),
        .eret            (eret),
        .epc             (epc),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .pc              (pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .flush           (flush),
        .perf_branches   (perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tg;
        logic        fl;
        logic [31:0] pb;
        logic [31:0] pm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural PC, a "delay slot pending" flag and a table of
    // remembered branches indexed by word address modulo ENTRIES.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_slot;
    bit          m_v    [ENTRIES];
    logic [31:0] m_addr [ENTRIES];
    logic [31:0] m_tgt  [ENTRIES];
    int          m_ctr  [ENTRIES];
    logic [31:0] m_nbr;
    logic [31:0] m_nmis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int i;
        i = slot_of(a);
        return m_v[i] && ((m_addr[i] >> 2) == (a >> 2));
    endfunction

    function automatic bit m_pred();
        return m_hit(m_pc) && (m_ctr[slot_of(m_pc)] >= 2) && !m_slot;
    endfunction

    function automatic bit m_mis();
        return res_valid && ((res_taken != res_pred_taken) ||
                             (res_taken && (res_target != res_pred_target)));
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        e.pc = m_pc;
        e.pt = m_pred();
        e.tg = e.pt ? m_tgt[slot_of(m_pc)] : 32'h0;
        e.fl = int_req || eret || m_mis();
`ifdef PC_GEN_PERF_EN
        e.pb = m_nbr;
        e.pm = m_nmis;
`else
        e.pb = 32'h0;
        e.pm = 32'h0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_pc   = RESET_ADDR;
        m_slot = 1'b0;
        m_pend = 32'h0;
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
        m_nbr  = 32'h0;
        m_nmis = 32'h0;
    endtask

    task automatic model_advance();
        bit          pt, mis;
        logic [31:0] ptg;
        int          i;
        pt  = m_pred();
        ptg = m_tgt[slot_of(m_pc)];
        mis = m_mis();
        if (int_req) begin
            m_pc = INT_ADDR; m_slot = 1'b0;
        end else if (eret) begin
            m_pc = epc; m_slot = 1'b0;
        end else if (mis) begin
            m_pc = res_taken ? res_target : res_pc + 32'd8; m_slot = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (pt) begin
            m_pend = ptg; m_pc = m_pc + 32'd4; m_slot = 1'b1;
        end else if (m_slot) begin
            m_pc = m_pend; m_slot = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        if (res_valid) begin
            i = slot_of(res_pc);
            if (m_hit(res_pc)) begin
                if (res_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = res_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (res_taken) begin
                m_v[i] = 1'b1; m_addr[i] = res_pc; m_tgt[i] = res_target; m_ctr[i] = 2;
            end
            m_nbr = m_nbr + 32'd1;
        end
        if (mis) m_nmis = m_nmis + 32'd1;
    endtask

    task automatic clear_inputs();
        stall = 0; int_req = 0; eret = 0; epc = 32'h0;
        res_valid = 0; res_pc = 32'h0; res_taken = 0; res_target = 32'h0;
        res_pred_taken = 0; res_pred_target = 32'h0;
    endtask

    task automatic tick();
        sb.push_back(m_expect());
        @(posedge clk);
        #1;
        model_advance();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic resolve(input logic [31:0] a, input logic t, input logic [31:0] tg,
                           input logic ppt, input logic [31:0] ptg);
        res_valid = 1; res_pc = a; res_taken = t; res_target = tg;
        res_pred_taken = ppt; res_pred_target = ptg;
    endtask

    task automatic eret_to(input logic [31:0] a);
        eret = 1; epc = a;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
            chk("sb_pred_target", pred_target, e.tg);
            chk("sb_flush", {31'b0, flush}, {31'b0, e.fl});
            chk("sb_perf_branches", perf_branches, e.pb);
            chk("sb_perf_mispredicts", perf_mispredicts, e.pm);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] pool [8];

    initial begin
        pool = '{32'hBFC00010, 32'hBFC00020, 32'h00000000, 32'h00000040,
                 32'hBFC00050, 32'h00001010, 32'hFFFFFFFC, 32'h00000400};
        reset = 1'b0;
        do_reset();

        // Reset state and free-running fetch
        chk("reset_pc", pc, 32'hBFC00000);
        chk("reset_pred", {31'b0, pred_taken}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("seq_pc", pc, 32'hBFC00000 + 32'(4 * k));
            chk("seq_pred", {31'b0, pred_taken}, 32'h0);
        end
        tick();
        chk("pc_10", pc, 32'hBFC00010);

        // Train the branch at BFC00010 -> BFC00100 twice
        for (int k = 0; k < 2; k++) begin
            resolve(32'hBFC00010, 1, 32'hBFC00100, 0, 32'h0);
            #1 chk("train_flush", {31'b0, flush}, 32'h1);
            tick();
            chk("train_pc", pc, 32'hBFC00100);
        end
        eret_to(32'hBFC00010);
        tick();
        chk("hit_pc", pc, 32'hBFC00010);
        chk("hit_pred", {31'b0, pred_taken}, 32'h1);
        chk("hit_target", pred_target, 32'hBFC00100);
        tick();
        chk("slot_pc", pc, 32'hBFC00014);
        chk("slot_pred", {31'b0, pred_taken}, 32'h0);
        #1 chk("slot_flush", {31'b0, flush}, 32'h0);
        tick();
        chk("redirect_pc", pc, 32'hBFC00100);

        // Not-taken resolutions weaken the counter 3 -> 2 -> 1
        for (int k = 0; k < 2; k++) begin
            resolve(32'hBFC00010, 0, 32'h0, 1, 32'hBFC00100);
            #1 chk("nt_flush", {31'b0, flush}, 32'h1);
            tick();
            chk("nt_pc", pc, 32'hBFC00018);
        end
        eret_to(32'hBFC00010);
        tick();
        chk("weak_pred", {31'b0, pred_taken}, 32'h0);

        // Interrupt beats eret, mispredict and stall; BTB still learns
        stall = 1; int_req = 1; eret_to(32'h12345678);
        resolve(32'hBFC00020, 1, 32'hBFC00200, 0, 32'h0);
        #1 chk("int_flush", {31'b0, flush}, 32'h1);
        tick();
        chk("int_pc", pc, INT_ADDR);
        eret_to(32'hBFC00020);
        tick();
        chk("int_btb_pred", {31'b0, pred_taken}, 32'h1);
        chk("int_btb_target", pred_target, 32'hBFC00200);

        // Aliasing: 00000040 evicts 00000000 at index 0
        resolve(32'h00000000, 1, 32'h00000500, 0, 32'h0);
        tick();
        chk("alias_pc0", pc, 32'h00000500);
        eret_to(32'h00000000);
        tick();
        chk("alias_hit0", {31'b0, pred_taken}, 32'h1);
        resolve(32'h00000040, 1, 32'h00000600, 0, 32'h0);
        tick();
        eret_to(32'h00000000);
        tick();
        chk("alias_miss0", {31'b0, pred_taken}, 32'h0);
        eret_to(32'h00000040);
        tick();
        chk("alias_hit40", {31'b0, pred_taken}, 32'h1);
        chk("alias_tgt40", pred_target, 32'h00000600);

        // PC wraps modulo 2^32
        eret_to(32'hFFFFFFFC);
        tick();
        tick();
        chk("wrap_pc", pc, 32'h00000000);

        // Reset in the middle of a delay slot discards the pending target
        eret_to(32'h00000040);
        tick();
        tick();
        chk("mid_slot_pc", pc, 32'h00000044);
        do_reset();
        chk("post_reset_pc", pc, RESET_ADDR);
        tick();
        chk("post_reset_pc1", pc, RESET_ADDR + 32'd4);
        eret_to(32'h00000040);
        tick();
        chk("post_reset_btb", {31'b0, pred_taken}, 32'h0);

        // Five resolutions, two of them mispredicted
        do_reset();
        resolve(32'h00000100, 1, 32'h00000200, 0, 32'h0);          tick();
        resolve(32'h00000300, 0, 32'h0, 0, 32'h0);                  tick();
        resolve(32'h00000400, 1, 32'h00000500, 1, 32'h00000500);    tick();
        resolve(32'h00000600, 1, 32'h00000700, 1, 32'h00000704);    tick();
        resolve(32'h00000800, 0, 32'h0, 0, 32'h0);                  tick();
`ifdef PC_GEN_PERF_EN
        chk("perf_branches", perf_branches, 32'd5);
        chk("perf_mispredicts", perf_mispredicts, 32'd2);
`else
        chk("perf_branches_off", perf_branches, 32'd0);
        chk("perf_mispredicts_off", perf_mispredicts, 32'd0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            stall   = ($urandom_range(0, 3) == 0);
            int_req = ($urandom_range(0, 40) == 0);
            eret    = ($urandom_range(0, 30) == 0);
            epc     = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 2) == 0) begin
                res_valid       = 1;
                res_pc          = pool[$urandom_range(0, 7)];
                res_taken       = $urandom_range(0, 1) == 1;
                res_target      = pool[$urandom_range(0, 7)];
                res_pred_taken  = ($urandom_range(0, 3) == 0) ? !res_taken : res_taken;
                res_pred_target = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)]
                                                               : res_target;
            end
            tick();
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
